serial_compare_scheduler: RTL and testbench
===========================================

// Module: serial_compare_scheduler
// PURPOSE
//  Shares one MSB-first serial comparator (serial_comparator_most_significant_first) among NUM_REQ
//  requesters, each offering a parallel WIDTH-bit operand pair. A round-robin arbiter grants one
//  request; the block shifts the pair MSB-first through the comparator and returns less/eq/greater
//  with the requester id over a valid/ready response port.
// PARAMETERS
//  NUM_REQ  4  number of requesters, >=2
//  WIDTH    8  operand width in bits, >=2
//  IDW      localparam = $clog2(NUM_REQ), width of rsp_id
// PORTS
//  clk          in   1              clock
//  rst          in   1              synchronous reset, active-high
//  req_valid    in   NUM_REQ        per-requester request valid
//  req_ready    out  NUM_REQ        per-requester accept (one-hot or zero)
//  req_a        in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b        in   NUM_REQ*WIDTH  operand B, same packing
//  rsp_valid    out  1              result valid
//  rsp_ready    in   1              downstream accepts result
//  rsp_id       out  IDW            index of the requester that owns the result
//  rsp_less     out  1              A < B (unsigned)
//  rsp_eq       out  1              A == B
//  rsp_greater  out  1              A > B
//  busy         out  1              state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id/rsp_less/rsp_eq/rsp_greater=0, req_ready=0.
//  - FSM states IDLE -> SHIFT -> RESP -> IDLE.
//  - IDLE: req_ready is combinational: one-hot on the first valid requester at or after rr_ptr
//    (wrapping); zero if none valid or rst=1. On acceptance (req_valid[g] & req_ready[g]):
//    capture a/b into shift registers, store id=g, set rr_ptr=(g+1) mod NUM_REQ, bit_cnt=0,
//    assert the comparator's reset this cycle, go to SHIFT.
//  - The comparator's reset = rst | acceptance. Its state is therefore eq=1/less=0 on the first
//    SHIFT cycle.
//  - SHIFT: drive the comparator with shift_a[WIDTH-1]/shift_b[WIDTH-1]. Shift both registers left
//    by 1 and increment bit_cnt each cycle. When bit_cnt==WIDTH-1, register the comparator's
//    combinational outputs into rsp_less/rsp_eq/rsp_greater and go to RESP.
//  - RESP: rsp_valid=1. Outputs are held stable until rsp_ready=1, then go to IDLE. req_ready=0
//    throughout SHIFT and RESP.
//  - Latency (no early exit): acceptance in cycle T -> rsp_valid high in cycle T+WIDTH+1.
//    Minimum spacing between acceptances is WIDTH+2 cycles.
//  - Exactly one of rsp_less/rsp_eq/rsp_greater is 1 whenever rsp_valid=1.
//  - Requests arriving or dropping during SHIFT/RESP are ignored. Operands are sampled only at
//    acceptance.
//  - rr_ptr changes only on acceptance. A requester whose valid stays high is served within
//    NUM_REQ grants.
//  - rst in any state returns to IDLE next cycle with reset values. An in-flight result is
//    discarded.
// CONFIGURATION
//  EARLY_EXIT_EN defined:
//    - In SHIFT, if the comparator's a_eq_b output is 0, register its outputs immediately and go
//      to RESP. The first differing bit at position WIDTH-1-k gives rsp_valid at T+k+2.
//    - Equal operands still take T+WIDTH+1.
//  EARLY_EXIT_EN undefined: always WIDTH SHIFT cycles. Results are identical in both builds.
// TESTING (WIDTH=8, NUM_REQ=4)
//  1. req0 a=8'hA5 b=8'hA5, rsp_ready=1 -> accepted cycle T. rsp_valid at T+9: eq=1, id=0,
//     less=greater=0.
//  2. req2 a=8'h80 b=8'h7F -> greater=1, id=2. rsp_valid at T+2 with EARLY_EXIT_EN, T+9 without.
//  3. req1 a=8'h01 b=8'h00 -> greater=1 at T+9 in both builds (LSB difference).
//     req3 a=8'h00 b=8'hFF -> less=1.
//  4. All four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0.
//     req_ready never has more than one bit set.
//  5. rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, busy=1.
//     After rsp_ready=1 the next grant is the following cycle.
//  6. rst pulsed mid-SHIFT -> next cycle busy=0, rsp_valid=0, rr_ptr=0.
//     A following req0 a=8'h10 b=8'h20 gives less=1 with normal latency.

Source files
------------

// File: rtl/serial_compare_scheduler_if.sv
// Request/response bundle for serial_compare_scheduler.
// Both channels use valid/ready: a transfer happens on a cycle where valid and ready are both high.
interface serial_compare_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic                     rsp_less;
    logic                     rsp_eq;
    logic                     rsp_greater;
    logic                     busy;
    logic [1:0]               dbg_state;
    logic [IDW-1:0]           dbg_rr_ptr;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_greater,
        input  busy, dbg_state, dbg_rr_ptr
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_less, rsp_eq, rsp_greater,
        output busy, dbg_state, dbg_rr_ptr
    );
endinterface

// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler sharing one MSB-first serial comparator among NUM_REQ requesters.
// Define EARLY_EXIT_EN to finish the shift as soon as the operands are known to differ.
module serial_comparator_most_significant_first (
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    input  logic b_i,
    output logic a_less_b_o,
    output logic a_eq_b_o,
    output logic a_greater_b_o
);
    logic eq_q;
    logic less_q;

    // Once a difference has been seen, the verdict is frozen in less_q / !eq_q.
    assign a_eq_b_o      = eq_q & (a_i ~^ b_i);
    assign a_less_b_o    = less_q | (eq_q & ~a_i & b_i);
    assign a_greater_b_o = ~a_eq_b_o & ~a_less_b_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_q   <= 1'b1;
            less_q <= 1'b0;
        end else begin
            eq_q   <= a_eq_b_o;
            less_q <= a_less_b_o;
        end
    end
endmodule

module serial_compare_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_compare_scheduler_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             less_q, less_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     cand;
    logic               grant_found;
    logic               accept;
    logic               cmp_rst;
    logic               cmp_less, cmp_eq, cmp_gt;
    logic               shift_done;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDW-1:0];
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_oh    = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(rr_ptr_q, k);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
        if (grant_found) grant_oh[grant_id] = 1'b1;
    end

    assign bus.req_ready = (state_q == S_IDLE && !rst) ? grant_oh : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign cmp_rst       = rst | accept;

    serial_comparator_most_significant_first u_cmp (
        .clk           (clk),
        .rst           (cmp_rst),
        .a_i           (shift_a_q[WIDTH-1]),
        .b_i           (shift_b_q[WIDTH-1]),
        .a_less_b_o    (cmp_less),
        .a_eq_b_o      (cmp_eq),
        .a_greater_b_o (cmp_gt)
    );

`ifdef EARLY_EXIT_EN
    assign shift_done = (bit_cnt_q == CW'(WIDTH - 1)) || !cmp_eq;
`else
    assign shift_done = (bit_cnt_q == CW'(WIDTH - 1));
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        shift_a_d   = shift_a_q;
        shift_b_d   = shift_b_q;
        bit_cnt_d   = bit_cnt_q;
        rsp_valid_d = rsp_valid_q;
        less_d      = less_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_a_d = bus.req_a[int'(grant_id) * WIDTH +: WIDTH];
                    shift_b_d = bus.req_b[int'(grant_id) * WIDTH +: WIDTH];
                    id_d      = grant_id;
                    rr_ptr_d  = wrap_add(grant_id, 1);
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_a_d = {shift_a_q[WIDTH-2:0], 1'b0};
                shift_b_d = {shift_b_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (shift_done) begin
                    less_d      = cmp_less;
                    eq_d        = cmp_eq;
                    gt_d        = cmp_gt;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            shift_a_q   <= '0;
            shift_b_q   <= '0;
            bit_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            less_q      <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            shift_a_q   <= shift_a_d;
            shift_b_q   <= shift_b_d;
            bit_cnt_q   <= bit_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            less_q      <= less_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_less    = less_q;
    assign bus.rsp_eq      = eq_q;
    assign bus.rsp_greater = gt_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.dbg_state   = state_q;
    assign bus.dbg_rr_ptr  = rr_ptr_q;
endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Bench for serial_compare_scheduler: directed table, reset-mid-shift sequence, random traffic.
module tb_serial_compare_scheduler;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_compare_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    serial_compare_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int model_rr = 0;
    logic [4:0] exp_q[$];  // {id, less, eq, greater}

    typedef struct {
        logic [3:0]  vmask;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [4:0]  exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model
    function automatic int model_grant(input logic [3:0] v, input int rr);
        int i;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (rr + k) % NUM_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [4:0] model_result(input int id, input logic [7:0] a, input logic [7:0] b);
        logic [1:0] idb;
        idb = id[1:0];
        return {idb, a < b, a == b, a > b};
    endfunction

    function automatic int model_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef EARLY_EXIT_EN
        for (int k = 0; k < WIDTH; k++)
            if (a[WIDTH-1-k] != b[WIDTH-1-k]) return k + 2;
`endif
        return WIDTH + 1;
    endfunction

    // driver: called at a negedge with the DUT idle, returns at a negedge with the DUT idle
    task automatic run_txn(input logic [3:0] vmask, input logic [31:0] a_pk, input logic [31:0] b_pk,
                           input int hold, input bit use_tbl, input logic [4:0] tbl_exp);
        int g, g2, lat, n;
        logic [7:0] a, b;
        logic [31:0] exp_oh;
        logic [4:0] exp_r, got;
        g = model_grant(vmask, model_rr);
        bus.req_valid = vmask;
        bus.req_a     = a_pk;
        bus.req_b     = b_pk;
        bus.rsp_ready = (hold == 0);
        #1;
        exp_oh = (g < 0) ? 32'd0 : (32'd1 << g);
        chk("req_ready_grant", 32'(bus.req_ready), exp_oh);
        chk("req_ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
        if (g < 0) return;
        a = a_pk[g*8 +: 8];
        b = b_pk[g*8 +: 8];
        exp_q.push_back(use_tbl ? tbl_exp : model_result(g, a, b));
        lat = model_lat(a, b);
        model_rr = (g + 1) % NUM_REQ;
        @(posedge clk);
        #1;
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        n = 1;
        @(negedge clk);
        while (!bus.rsp_valid && n < 24) begin
            chk("shift_busy_noready", {27'd0, bus.busy, bus.req_ready}, {27'd0, 1'b1, 4'b0});
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        chk("latency", n, lat);
        exp_r = exp_q.pop_front();
        got = {bus.rsp_id, bus.rsp_less, bus.rsp_eq, bus.rsp_greater};
        chk("rsp_fields", 32'(got), 32'(exp_r));
        chk("rsp_onehot", $countones({bus.rsp_less, bus.rsp_eq, bus.rsp_greater}), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            got = {bus.rsp_id, bus.rsp_less, bus.rsp_eq, bus.rsp_greater};
            chk("hold_stable", {26'd0, bus.rsp_valid, got}, {26'd0, 1'b1, exp_r});
            chk("hold_busy_noready", {27'd0, bus.busy, bus.req_ready}, {27'd0, 1'b1, 4'b0});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("back_idle", {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
        g2 = model_grant(vmask, model_rr);
        chk("regrant_next_cycle", 32'(bus.req_ready), (g2 < 0) ? 32'd0 : (32'd1 << g2));
        bus.req_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a_pk, b_pk;
        logic [7:0]  ab, bb;

        tbl[0] = '{4'b0001, 32'h000000A5, 32'h000000A5, 0, 5'b00_010};
        tbl[1] = '{4'b0100, 32'h00800000, 32'h007F0000, 0, 5'b10_001};
        tbl[2] = '{4'b0010, 32'h00000100, 32'h00000000, 0, 5'b01_001};
        tbl[3] = '{4'b1000, 32'h00000000, 32'hFF000000, 0, 5'b11_100};
        tbl[4] = '{4'b1111, 32'h7EF05512, 32'h7F0F5534, 0, 5'b00_100};
        tbl[5] = '{4'b1111, 32'h7EF05512, 32'h7F0F5534, 0, 5'b01_010};
        tbl[6] = '{4'b1111, 32'h7EF05512, 32'h7F0F5534, 0, 5'b10_001};
        tbl[7] = '{4'b1111, 32'h7EF05512, 32'h7F0F5534, 0, 5'b11_100};
        tbl[8] = '{4'b1111, 32'h7EF05512, 32'h7F0F5534, 0, 5'b00_100};
        tbl[9] = '{4'b0001, 32'h000000C3, 32'h000000C3, 5, 5'b00_010};

        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_busy_valid", {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
        chk("reset_fields", 32'({bus.rsp_id, bus.rsp_less, bus.rsp_eq, bus.rsp_greater}), 32'd0);
        chk("reset_rr_ptr", 32'(bus.dbg_rr_ptr), 32'd0);
        rst = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].vmask, tbl[i].a, tbl[i].b, tbl[i].hold, 1'b1, tbl[i].exp);

        // reset in the middle of a shift discards the in-flight result
        bus.req_valid = 4'b0001;
        bus.req_a = 32'h00000010;
        bus.req_b = 32'h00000020;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        chk("pre_rst_rr_ptr", 32'(bus.dbg_rr_ptr), 32'd1);
        rst = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_busy_valid", {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
        chk("post_rst_rr_ptr", 32'(bus.dbg_rr_ptr), 32'd0);
        model_rr = 0;
        run_txn(4'b0001, 32'h00000010, 32'h00000020, 0, 1'b1, 5'b00_100);

        // random traffic against the model
        for (int t = 0; t < 40; t++) begin
            a_pk = $urandom;
            b_pk = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                ab = a_pk[i*8 +: 8];
                case ($urandom_range(0, 2))
                    0:       bb = ab;
                    1:       bb = ab ^ (8'd1 << $urandom_range(0, 7));
                    default: bb = 8'($urandom);
                endcase
                b_pk[i*8 +: 8] = bb;
            end
            run_txn(4'($urandom_range(1, 15)), a_pk, b_pk, $urandom_range(0, 2), 1'b0, 5'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
